// File: rtl/bus_master.sv
// bus_master -- single-transaction Wishbone-style initiator for the 16-bit bus.
//
// Takes one read/write command at a time on a valid/ready port. It drives
// cyc/stb/we/sel/adr/dat onto the bus and waits for ack or err from the
// responder. If neither arrives within TIMEOUT stb cycles it aborts. The
// response is held until the local side consumes it.
//
// Ports
//   clk_i, rst_i        clock, async active-high reset
//   cmd_*               command port (valid/ready, we, adr, sel, dat)
//   rsp_*               held response (valid/ready, dat, err, timeout)
//   err_cnt_o           saturating count of err/timeout completions
//   cyc_o .. dat_o      bus initiator outputs
//   dat_i, ack_i, err_i responder return
module bus_master #(
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [1:0]            cmd_sel_i,
  input  logic [15:0]           cmd_dat_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [15:0]           rsp_dat_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  output logic [7:0]            err_cnt_o,
  output logic                  cyc_o,
  output logic                  stb_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [1:0]            sel_o,
  output logic [15:0]           dat_o,
  input  logic [15:0]           dat_i,
  input  logic                  ack_i,
  input  logic                  err_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int            CW     = $clog2(TIMEOUT);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          done;
  logic          fail;

  // The counter is cleared on accept and counts completed stb cycles. When it
  // reaches TIMEOUT-1 at an edge, stb has been high for TIMEOUT cycles.
  assign done = err_i || ack_i || (cnt == T_LAST);
  // Error priority: err_i, then ack_i. A plain timeout is also an error.
  assign fail = err_i || !ack_i;

  assign cmd_ready_o = (state == S_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      cnt           <= '0;
      cyc_o         <= 1'b0;
      stb_o         <= 1'b0;
      we_o          <= 1'b0;
      adr_o         <= '0;
      sel_o         <= '0;
      dat_o         <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_dat_o     <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
      err_cnt_o     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            we_o  <= cmd_we_i;
            adr_o <= cmd_adr_i;
            sel_o <= cmd_sel_i;
            dat_o <= cmd_dat_i;
            cyc_o <= 1'b1;
            stb_o <= 1'b1;
            cnt   <= '0;
            state <= S_BUS;
          end
        end
        S_BUS: begin
          if (done) begin
            cyc_o         <= 1'b0;
            stb_o         <= 1'b0;
            we_o          <= 1'b0;
            rsp_valid_o   <= 1'b1;
            rsp_err_o     <= fail;
            rsp_timeout_o <= !err_i && !ack_i;
            rsp_dat_o     <= (!err_i && ack_i && !we_o) ? dat_i : 16'h0000;
            if (fail && err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
            state         <= S_RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RESP: begin
          // Returning to IDLE takes this edge, so no command is accepted here.
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master.sv
module tb_bus_master;
  localparam int TO = 5;
  localparam int K_ACK = 0, K_ERR = 1, K_BOTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_we = 1'b0, rsp_ready = 1'b0;
  logic [15:0] cmd_adr = '0, cmd_dat = '0;
  logic [1:0]  cmd_sel = '0;
  logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout;
  logic [15:0] rsp_dat;
  logic [7:0]  err_cnt;
  logic        cyc, stb, we;
  logic [15:0] adr, dat_o;
  logic [1:0]  sel;
  logic [15:0] dat_r = '0;
  logic        ack_r = 1'b0, err_r = 1'b0, spur_ack = 1'b0, spur_err = 1'b0;
  logic        ack, err;

  int n_tests = 0, n_fail = 0;

  // responder controls and storage
  int          r_kind = K_ACK;
  logic [7:0]  r_dly = 8'd255;
  logic [7:0]  scnt = '0;
  logic [15:0] mem [16];
  // reference state
  logic [15:0] model_mem [16];
  int          m_errcnt = 0;

  always #5 clk = ~clk;

  assign ack = ack_r | spur_ack;
  assign err = err_r | spur_err;

  bus_master #(.ADDR_WIDTH(16), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_sel_i(cmd_sel), .cmd_dat_i(cmd_dat),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout), .err_cnt_o(err_cnt),
    .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr), .sel_o(sel), .dat_o(dat_o),
    .dat_i(dat_r), .ack_i(ack), .err_i(err)
  );

  // Registered responder: answers r_dly cycles after first seeing stb
  // (r_dly = 0 gives the classic ack one cycle after stb).
  always @(posedge clk) begin
    ack_r <= 1'b0;
    err_r <= 1'b0;
    scnt  <= stb ? scnt + 8'd1 : 8'd0;
    if (stb && scnt == r_dly && !(ack_r || err_r)) begin
      ack_r <= (r_kind != K_ERR);
      err_r <= (r_kind != K_ACK);
      dat_r <= mem[adr[3:0]];
      if (we && r_kind == K_ACK) begin
        if (sel[0]) mem[adr[3:0]][7:0]  <= dat_o[7:0];
        if (sel[1]) mem[adr[3:0]][15:8] <= dat_o[15:8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_cmd(input logic w, input logic [15:0] a, input logic [1:0] s,
                         input logic [15:0] d, input int kind, input int dly, input int hold);
    bit          answered;
    int          e_stb, nstb, lat;
    logic        e_err, e_to;
    logic [15:0] e_dat, mask, f_dat;
    logic        f_err, f_to;
    // expectation from the protocol rules
    answered = (dly + 2 <= TO);
    e_stb    = answered ? dly + 2 : TO;
    e_err    = answered ? (kind != K_ACK) : 1'b1;
    e_to     = !answered;
    e_dat    = (answered && kind == K_ACK && !w) ? model_mem[a[3:0]] : 16'h0000;
    if (answered && kind == K_ACK && w) begin
      mask = {{8{s[1]}}, {8{s[0]}}};
      model_mem[a[3:0]] = (model_mem[a[3:0]] & ~mask) | (d & mask);
    end
    if (e_err) m_errcnt = (m_errcnt >= 255) ? 255 : m_errcnt + 1;

    @(negedge clk);
    r_kind = kind; r_dly = 8'(dly);
    cmd_we = w; cmd_adr = a; cmd_sel = s; cmd_dat = d; cmd_valid = 1'b1;
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("bus_drive", {cyc, stb, we, sel, adr, dat_o}, {1'b1, 1'b1, w, s, a, d});
    nstb = 0; lat = 0;
    while (!rsp_valid && lat < 200) begin
      if (stb) nstb++;
      @(posedge clk); #1;
      lat++;
    end
    chk("rsp_wait", lat < 200, 1'b1);
    chk("stb_cycles", nstb, e_stb);
    chk("rsp_latency", lat, e_stb);
    chk("bus_idle", {cyc, stb, we}, 3'b000);
    chk("rsp_dat", rsp_dat, e_dat);
    chk("rsp_err", rsp_err, e_err);
    chk("rsp_timeout", rsp_timeout, e_to);
    chk("err_cnt", err_cnt, m_errcnt);
    f_dat = rsp_dat; f_err = rsp_err; f_to = rsp_timeout;
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_frozen", {rsp_valid, cmd_ready, rsp_dat, rsp_err, rsp_to_w(f_to)},
          {1'b1, 1'b0, f_dat, f_err, f_to});
    end
    // consume with a new command already offered: it must not be taken
    @(negedge clk);
    rsp_ready = 1'b1; cmd_valid = 1'b1;
    @(posedge clk); #1;
    chk("consume", {rsp_valid, cmd_ready, stb}, 3'b010);
    @(negedge clk);
    rsp_ready = 1'b0; cmd_valid = 1'b0;
  endtask

  function automatic logic rsp_to_w(input logic unused);
    return rsp_timeout;
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i] = 16'(i * 16'h1111);
      model_mem[i] = 16'(i * 16'h1111);
    end
    mem[3] = 16'hBEEF; model_mem[3] = 16'hBEEF;
    mem[5] = 16'hFFFF; model_mem[5] = 16'hFFFF;
    #12;
    chk("reset_out", {cyc, stb, we, rsp_valid, rsp_err, rsp_timeout, adr, sel, dat_o, rsp_dat, err_cnt},
        '0);
    chk("reset_ready", cmd_ready, 1'b1);
    @(negedge clk); rst = 1'b0;

    // directed cases
    run_cmd(1'b0, 16'd3, 2'b11, 16'h0, K_ACK, 0, 0);
    chk("read_beef", rsp_dat, 16'hBEEF);
    run_cmd(1'b1, 16'd5, 2'b01, 16'h12AB, K_ACK, 0, 0);
    run_cmd(1'b0, 16'd5, 2'b11, 16'h0, K_ACK, 0, 0);
    chk("byte_write_rb", rsp_dat, 16'hFFAB);
    run_cmd(1'b1, 16'd7, 2'b11, 16'h5555, K_ERR, 0, 0);
    chk("err_cnt_one", err_cnt, 8'd1);
    run_cmd(1'b0, 16'd3, 2'b11, 16'h0, K_BOTH, 0, 0);
    run_cmd(1'b0, 16'd3, 2'b11, 16'h0, K_ACK, TO - 2, 0);
    run_cmd(1'b0, 16'd3, 2'b11, 16'h0, K_ACK, TO - 1, 0);
    run_cmd(1'b0, 16'd2, 2'b11, 16'h0, K_ACK, 255, 0);
    run_cmd(1'b0, 16'd3, 2'b10, 16'h0, K_ACK, 1, 10);

    // ack/err outside BUS are ignored
    @(negedge clk); spur_ack = 1'b1; spur_err = 1'b1;
    @(posedge clk); #1;
    chk("spurious_idle", {stb, rsp_valid, cmd_ready}, 3'b001);
    @(negedge clk); spur_ack = 1'b0; spur_err = 1'b0;
    chk("spurious_errcnt", err_cnt, m_errcnt);

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      int dly;
      dly = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, TO - 2);
      run_cmd(1'($urandom), 16'($urandom), 2'($urandom), 16'($urandom),
              $urandom_range(0, 2), dly, $urandom_range(0, 2));
    end

    // saturation
    for (int i = 0; i < 300; i++)
      run_cmd(1'b0, 16'($urandom), 2'b11, 16'h0, K_ACK, 255, 0);
    chk("errcnt_sat", err_cnt, 8'd255);

    // reset in the middle of BUS
    @(negedge clk);
    r_dly = 8'd255; cmd_we = 1'b1; cmd_adr = 16'd9; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("pre_reset_stb", {cyc, stb}, 2'b11);
    #2 rst = 1'b1;
    #1;
    chk("async_drop", {cyc, stb}, 2'b00);
    @(negedge clk); rst = 1'b0; m_errcnt = 0;
    @(posedge clk); #1;
    chk("post_reset", {cmd_ready, rsp_valid, stb, err_cnt}, {1'b1, 1'b0, 1'b0, 8'd0});
    run_cmd(1'b0, 16'd3, 2'b11, 16'h0, K_ACK, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/bus_master.md
# bus_master

Single-transaction Wishbone-style initiator for the 16-bit system bus. Accepts one read or write command at a time from a local valid/ready port and drives cyc/stb/we/sel/adr/dat onto the bus. It waits for ack or err from the addressed responder, or aborts after a programmable timeout, and returns a held response. It drives the bus RAM/ROM responders and peripheral register blocks from CPU-side and debug-side logic.

## Interface
- ADDR_WIDTH, 16: width of cmd_adr_i / adr_o.
- TIMEOUT, 16: maximum cycles stb_o stays asserted without ack/err; legal range 2..65535.
- clk_i  in  1  single clock; all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  high exactly when state is IDLE.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  ADDR_WIDTH  word address.
- cmd_sel_i  in  2  byte lane select ([0] = bits 7:0, [1] = bits 15:8).
- cmd_dat_i  in  16  write data.
- rsp_valid_o  out  1  response held until rsp_ready_i.
- rsp_ready_i  in  1  response consumed.
- rsp_dat_o  out  16  read data.
- rsp_err_o  out  1  transaction ended by err_i or timeout.
- rsp_timeout_o  out  1  transaction ended by timeout.
- err_cnt_o  out  8  saturating count of err/timeout completions.
- cyc_o, stb_o, we_o  out  1 each  bus strobes.
- adr_o  out  ADDR_WIDTH, sel_o  out  2, dat_o  out  16  bus address, lanes and write data.
- dat_i  in  16, ack_i  in  1, err_i  in  1  responder return.

## Operation
- States: IDLE, BUS, RESP.
- IDLE: cmd_ready_o = 1. If cmd_valid_i is high at a clock edge:
  - register we/adr/sel/dat onto we_o/adr_o/sel_o/dat_o;
  - set cyc_o = stb_o = 1;
  - clear the timeout counter;
  - go to BUS.
- BUS: bus outputs held stable. At each edge:
  - if err_i: rsp_err_o = 1, rsp_timeout_o = 0, rsp_dat_o = 0.
  - else if ack_i: rsp_err_o = 0, rsp_timeout_o = 0; rsp_dat_o = dat_i for a read, 16'h0000 for a write.
  - else if the counter equals TIMEOUT-1: rsp_err_o = 1, rsp_timeout_o = 1, rsp_dat_o = 0.
  - else: counter increments.
- On any of the three BUS completions: cyc_o = stb_o = we_o = 0, rsp_valid_o = 1, go to RESP.
- Priority within one edge: err_i > ack_i > timeout.
- RESP: response fields frozen. When rsp_ready_i is high, rsp_valid_o = 0 and the block returns to IDLE. No new command is accepted in the same edge.
- err_cnt_o increments on every completion with rsp_err_o = 1, saturating at 255. It is cleared only by reset.
- ack_i/err_i seen outside BUS are ignored.
- Timeout counter width: $clog2(TIMEOUT).

## Timing
- Reset values: state IDLE; cyc_o, stb_o, we_o, rsp_valid_o, rsp_err_o, rsp_timeout_o = 0; adr_o, sel_o, dat_o, rsp_dat_o, err_cnt_o = 0.
- Reset asserted mid-BUS drops cyc_o/stb_o asynchronously, without waiting for a clock. Any in-flight transaction is abandoned with no response.
- Accept at edge N: stb_o high from N.
- With a responder that registers ack one cycle after seeing stb (ack high after N+1), completion is at edge N+2:
  - stb_o low and rsp_valid_o high after N+2;
  - stb_o is high for exactly 2 cycles, so the responder cannot re-trigger.
- Timeout: stb_o is high for exactly TIMEOUT cycles; rsp_valid_o rises at the edge that drops stb_o.
- Minimum command-to-command spacing is 4 edges: accept, complete, consume, return to IDLE (next accept).

## Test plan
- Read: responder word at address 3 = 16'hBEEF; cmd read adr 3, sel 2'b11 -> stb_o high 2 cycles; rsp_valid_o after accept+2; rsp_dat_o = 16'hBEEF; rsp_err_o = 0; err_cnt_o = 0.
- Byte write then read-back: write adr 5, sel 2'b01, dat 16'h12AB over prior 16'hFFFF -> rsp_dat_o = 0, err 0; read adr 5 -> 16'hFFAB.
- Error: responder returns err_i on a write, TIMEOUT = 16 -> rsp_err_o = 1, rsp_timeout_o = 0, err_cnt_o = 1, stb_o high exactly 2 cycles.
- Timeout: no responder, TIMEOUT = 5 -> stb_o high exactly 5 cycles, then rsp_err_o = 1, rsp_timeout_o = 1. Repeating 300 times -> err_cnt_o saturates at 255.
- Simultaneous events:
  - ack_i and err_i high on the same edge -> error response.
  - ack_i on the final timeout cycle -> normal ack response, rsp_timeout_o = 0.
  - rsp_ready_i held low for 10 cycles -> response fields and cmd_ready_o = 0 stable throughout.
- Reset mid-operation: assert rst_i between clock edges while in BUS -> cyc_o/stb_o low before the next edge. After release: IDLE, cmd_ready_o = 1, rsp_valid_o = 0, err_cnt_o = 0.
